mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF stage (instruction read) and the MEM stage (data read/write) of the RV32IM pipeline.
- Grants one requester at a time and holds the grant until the memory acknowledges.
- Drives the memory-side address, data and funct3 select, and generates per-requester BUSYWAIT stalls.
- Includes a watchdog so that a hung memory cannot deadlock the pipeline.

Parameters:
- TIMEOUT, 255: cycles in a grant state without M_ACK before a forced completion. 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter. Requires TIMEOUT < 2^CNT_W.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- I_READ  in  1  instruction read request, held until I_BUSYWAIT=0
- I_ADDR  in  32  instruction address
- I_READDATA  out  32  instruction data
- I_BUSYWAIT  out  1  stall to IF stage
- D_READ  in  1  data read request
- D_WRITE  in  1  data write request; D_READ and D_WRITE are never both 1
- D_ADDR  in  32  data address
- D_WRITEDATA  in  32  store data
- D_FUNCT3  in  3  load/store size and sign (RV32 funct3 encoding)
- D_READDATA  out  32  load data
- D_BUSYWAIT  out  1  stall to MEM stage
- M_READ  out  1  memory read strobe
- M_WRITE  out  1  memory write strobe
- M_ADDR  out  32  memory address
- M_WRITEDATA  out  32  memory write data
- M_FUNCT3  out  3  memory size select
- M_READDATA  in  32  memory read data, valid when M_ACK=1
- M_ACK  in  1  one-cycle completion pulse from memory
- TIMEOUT_ERR  out  1  sticky watchdog flag

Behaviour:
- Reset: state IDLE; M_READ, M_WRITE, M_ADDR, M_WRITEDATA, M_FUNCT3 all 0; I_READDATA, D_READDATA, TIMEOUT_ERR and the watchdog counter all 0. RESET asserted mid-transaction abandons the transaction, and the strobes drop on the next cycle.
- States: IDLE, GNT_I, GNT_D.
  - All M_* outputs are decoded from the state register only; no combinational path from a request input to a strobe.
  - IDLE: all M_* are 0.
  - GNT_I: M_READ=1, M_ADDR=I_ADDR, M_FUNCT3=3'b010, M_WRITEDATA=0.
  - GNT_D: M_READ=D_READ, M_WRITE=D_WRITE, M_ADDR=D_ADDR, M_WRITEDATA=D_WRITEDATA, M_FUNCT3=D_FUNCT3.
- IDLE transitions:
  - D request (D_READ|D_WRITE) goes to GNT_D, even if I_READ is also set. MEM is the older instruction and has priority.
  - Otherwise I_READ goes to GNT_I.
  - Otherwise stay in IDLE.
- Grant-state transitions: stay until a completion edge, which is M_ACK=1 or a watchdog expiry. At the completion edge:
  - Go to the other requester's grant if that requester is requesting in that cycle.
  - Otherwise go to IDLE.
  - The just-served requester is excluded at that edge, because its request is still the completed one. This gives alternation under contention and no starvation.
- Handshake, requester side:
  - I_BUSYWAIT = I_READ & ~(GNT_I & done).
  - D_BUSYWAIT = (D_READ|D_WRITE) & ~(GNT_D & done).
  - done = M_ACK | wd_expire. Combinational, so the stall drops in the completion cycle.
- Read data:
  - While granted with done=1, X_READDATA passes M_READDATA through combinationally. On wd_expire it passes 32'h0 instead.
  - The same value is registered at the completion edge; outside the completion cycle, X_READDATA shows the registered value.
- Minimum latency: request in cycle 0 (IDLE), strobe in cycle 1, M_ACK in cycle 1 completes. That is a 1-cycle stall. Back-to-back I/D transfers have no idle bubble.
- Request withdrawn mid-grant (flush): the memory operation is not cancelled. The grant is held until done, and the result is still registered but unused.
- M_ACK outside a grant state is ignored.
- Watchdog:
  - The counter clears on entry to a grant state and on completion, and increments each grant cycle without M_ACK.
  - wd_expire = (TIMEOUT!=0) & (cnt==TIMEOUT-1) & ~M_ACK.
  - On expiry: TIMEOUT_ERR is set and stays 1 until RESET.
  - M_ACK and expiry in the same cycle count as a normal ack, with no error.

Test Plan:
- Reset then idle: RESET=1 for 2 cycles, then no requests. All M_* = 0, both BUSYWAITs 0, TIMEOUT_ERR=0.
- Single fetch: I_READ=1, I_ADDR=0x100, memory acks in cycle 3 with 0x00A00093. M_READ=1, M_FUNCT3=3'b010 in cycles 1-3; I_BUSYWAIT=1 in cycles 0-2 and 0 in cycle 3; I_READDATA=0x00A00093.
- Simultaneous requests: I_READ and D_WRITE (0x200, 0xDEADBEEF, funct3=3'b001) both raised in cycle 0, ack latency 1. Sequence is GNT_D then GNT_I with no IDLE between; M_FUNCT3=3'b001 during the write; I_BUSYWAIT stays 1 until the I ack.
- Alternation: both requesters re-request immediately after every completion for 6 transfers. The grant order is D, I, D, I, D, I.
- Flush mid-grant: drop D_READ 1 cycle after the grant, ack 2 cycles later. M_READ is held until the ack, then the state returns to IDLE.
- Watchdog: TIMEOUT=4, D_READ with no M_ACK. In the 4th grant cycle D_BUSYWAIT=0 and D_READDATA=0; TIMEOUT_ERR=1 and stays 1 until RESET.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory port: MEM-stage data accesses win over IF fetches,
// grants are held until M_ACK, and a watchdog forces completion if memory never answers.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_READ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_READDATA,
    output logic        I_BUSYWAIT,
    input  logic        D_READ,
    input  logic        D_WRITE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WRITEDATA,
    input  logic [2:0]  D_FUNCT3,
    output logic [31:0] D_READDATA,
    output logic        D_BUSYWAIT,
    output logic        M_READ,
    output logic        M_WRITE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WRITEDATA,
    output logic [2:0]  M_FUNCT3,
    input  logic [31:0] M_READDATA,
    input  logic        M_ACK,
    output logic        TIMEOUT_ERR
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] wd_cnt;
    logic             d_wr_q;
    logic [31:0]      i_data_q;
    logic [31:0]      d_data_q;
    logic             err_q;

    logic             d_req;
    logic             in_grant;
    logic             wd_expire;
    logic             done;
    logic             i_done;
    logic             d_done;
    logic [31:0]      result;

    assign d_req     = D_READ | D_WRITE;
    assign in_grant  = (state == GNT_I) || (state == GNT_D);
    assign wd_expire = (TIMEOUT != 0) && in_grant && (wd_cnt == WD_LAST) && !M_ACK;
    assign done      = in_grant && (M_ACK || wd_expire);
    assign i_done    = (state == GNT_I) && done;
    assign d_done    = (state == GNT_D) && done;
    // A watchdog-forced completion must never hand stale bus data to the pipeline.
    assign result    = wd_expire ? 32'h0 : M_READDATA;

    // At a completion edge the served side is skipped so contention alternates.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_req)       state_next = GNT_D;
                else if (I_READ) state_next = GNT_I;
            end
            GNT_I: begin
                if (done) state_next = d_req ? GNT_D : IDLE;
            end
            GNT_D: begin
                if (done) state_next = I_READ ? GNT_I : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            wd_cnt   <= '0;
            d_wr_q   <= 1'b0;
            i_data_q <= 32'h0;
            d_data_q <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (!in_grant || done) wd_cnt <= '0;
            else                   wd_cnt <= wd_cnt + 1'b1;
            // Latch the data op kind on grant so the strobes depend only on registered state.
            if ((state_next == GNT_D) && (state != GNT_D)) d_wr_q <= D_WRITE;
            if (i_done)    i_data_q <= result;
            if (d_done)    d_data_q <= result;
            if (wd_expire) err_q    <= 1'b1;
        end
    end

    always_comb begin
        M_READ      = 1'b0;
        M_WRITE     = 1'b0;
        M_ADDR      = 32'h0;
        M_WRITEDATA = 32'h0;
        M_FUNCT3    = 3'b000;
        case (state)
            GNT_I: begin
                M_READ   = 1'b1;
                M_ADDR   = I_ADDR;
                M_FUNCT3 = 3'b010;
            end
            GNT_D: begin
                M_READ      = !d_wr_q;
                M_WRITE     = d_wr_q;
                M_ADDR      = D_ADDR;
                M_WRITEDATA = D_WRITEDATA;
                M_FUNCT3    = D_FUNCT3;
            end
            default: ;
        endcase
    end

    assign I_BUSYWAIT  = I_READ && !i_done;
    assign D_BUSYWAIT  = d_req && !d_done;
    assign I_READDATA  = i_done ? result : i_data_q;
    assign D_READDATA  = d_done ? result : d_data_q;
    assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of who owns the port and for how long.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_readdata;
    logic        i_busywait;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_writedata;
    logic [2:0]  d_funct3;
    logic [31:0] d_readdata;
    logic        d_busywait;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_writedata;
    logic [2:0]  m_funct3;
    logic [31:0] m_readdata;
    logic        m_ack;
    logic        timeout_err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: owner 0 = nobody, 1 = fetch side, 2 = data side.
    int          m_owner  = 0;
    int          m_cycles = 0;
    bit          m_dwrite = 0;
    logic [31:0] m_idata  = 32'h0;
    logic [31:0] m_ddata  = 32'h0;
    bit          m_err    = 0;
    bit          e_expire;
    bit          e_done;
    bit          e_ibusy;
    bit          e_dbusy;
    logic [31:0] e_result;

    always #5 clock = ~clock;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .CLK         (clock),
        .RESET       (reset),
        .I_READ      (i_read),
        .I_ADDR      (i_addr),
        .I_READDATA  (i_readdata),
        .I_BUSYWAIT  (i_busywait),
        .D_READ      (d_read),
        .D_WRITE     (d_write),
        .D_ADDR      (d_addr),
        .D_WRITEDATA (d_writedata),
        .D_FUNCT3    (d_funct3),
        .D_READDATA  (d_readdata),
        .D_BUSYWAIT  (d_busywait),
        .M_READ      (m_read),
        .M_WRITE     (m_write),
        .M_ADDR      (m_addr),
        .M_WRITEDATA (m_writedata),
        .M_FUNCT3    (m_funct3),
        .M_READDATA  (m_readdata),
        .M_ACK       (m_ack),
        .TIMEOUT_ERR (timeout_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs mid-cycle and, when enabled, compares every output with the model.
    task automatic applyStimulus(input bit chk, input bit rst, input bit ird, input logic [31:0] iad,
                                 input bit drd, input bit dwr, input logic [31:0] dad,
                                 input logic [31:0] dwd, input logic [2:0] f3,
                                 input bit ack, input logic [31:0] mrd);
        reset = rst; i_read = ird; i_addr = iad; d_read = drd; d_write = dwr;
        d_addr = dad; d_writedata = dwd; d_funct3 = f3; m_ack = ack; m_readdata = mrd;
        #1;
        e_expire = (m_owner != 0) && (m_cycles == TIMEOUT) && !ack;
        e_done   = (m_owner != 0) && (ack || e_expire);
        e_result = e_expire ? 32'h0 : mrd;
        e_ibusy  = ird && !(m_owner == 1 && e_done);
        e_dbusy  = (drd || dwr) && !(m_owner == 2 && e_done);
        if (chk) begin
            checkOutput("m_read",      m_read,      (m_owner == 1) || (m_owner == 2 && !m_dwrite));
            checkOutput("m_write",     m_write,     (m_owner == 2) && m_dwrite);
            checkOutput("m_addr",      m_addr,      (m_owner == 1) ? iad : (m_owner == 2) ? dad : 32'h0);
            checkOutput("m_writedata", m_writedata, (m_owner == 2) ? dwd : 32'h0);
            checkOutput("m_funct3",    m_funct3,    (m_owner == 1) ? 32'd2 : (m_owner == 2) ? {29'b0, f3} : 32'd0);
            checkOutput("i_busywait",  i_busywait,  e_ibusy);
            checkOutput("d_busywait",  d_busywait,  e_dbusy);
            checkOutput("i_readdata",  i_readdata,  (m_owner == 1 && e_done) ? e_result : m_idata);
            checkOutput("d_readdata",  d_readdata,  (m_owner == 2 && e_done) ? e_result : m_ddata);
            checkOutput("timeout_err", timeout_err, m_err);
        end
    endtask

    // Advances the model by one clock using the inputs currently applied, then steps the DUT.
    task automatic finishCycle();
        if (reset) begin
            m_owner = 0; m_cycles = 0; m_dwrite = 0;
            m_idata = 32'h0; m_ddata = 32'h0; m_err = 0;
        end else if (m_owner == 0) begin
            if (d_read || d_write) begin
                m_owner = 2; m_dwrite = d_write; m_cycles = 1;
            end else if (i_read) begin
                m_owner = 1; m_cycles = 1;
            end
        end else if (e_done) begin
            if (m_owner == 1) m_idata = e_result;
            else              m_ddata = e_result;
            if (e_expire) m_err = 1;
            if (m_owner == 1 && (d_read || d_write)) begin
                m_owner = 2; m_dwrite = d_write;
            end else if (m_owner == 2 && i_read) begin
                m_owner = 1;
            end else begin
                m_owner = 0;
            end
            m_cycles = 1;
        end else begin
            m_cycles++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idleCycle(input bit rst);
        applyStimulus(1, rst, 0, 32'h0, 0, 0, 32'h0, 32'h0, 3'b000, 0, 32'hFFFF_FFFF);
        finishCycle();
    endtask

    bit          i_pend, d_pend, d_pend_wr, rst_r;
    logic [31:0] i_pend_addr, d_pend_addr, d_pend_wd;
    logic [2:0]  d_pend_f3;

    initial begin
        // Reset then idle; the very first cycle precedes any clock edge.
        applyStimulus(0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 3'b000, 0, 32'h0);
        finishCycle();
        idleCycle(1);
        for (int c = 0; c < 3; c++) begin
            idleCycle(0);
            checkOutput("idle_err", timeout_err, 32'd0);
        end

        // Single fetch, ack in cycle 3.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1, 0, 1, 32'h100, 0, 0, 32'h0, 32'h0, 3'b000, c == 3,
                          (c == 3) ? 32'h00A0_0093 : 32'h5555_5555);
            checkOutput("fetch_busy",  i_busywait, (c < 3) ? 32'd1 : 32'd0);
            checkOutput("fetch_mread", m_read,     (c >= 1) ? 32'd1 : 32'd0);
            checkOutput("fetch_f3",    m_funct3,   (c >= 1) ? 32'd2 : 32'd0);
            finishCycle();
        end
        applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 3'b000, 0, 32'h0);
        checkOutput("fetch_data", i_readdata, 32'h00A0_0093);
        finishCycle();

        // Simultaneous write and fetch: data first, fetch immediately after.
        applyStimulus(1, 0, 1, 32'h104, 0, 1, 32'h200, 32'hDEAD_BEEF, 3'b001, 1, 32'h1111_1111);
        checkOutput("sim_c0_write", m_write, 32'd0);
        finishCycle();
        applyStimulus(1, 0, 1, 32'h104, 0, 1, 32'h200, 32'hDEAD_BEEF, 3'b001, 1, 32'h2222_2222);
        checkOutput("sim_c1_write", m_write,    32'd1);
        checkOutput("sim_c1_f3",    m_funct3,   32'd1);
        checkOutput("sim_c1_ibusy", i_busywait, 32'd1);
        finishCycle();
        applyStimulus(1, 0, 1, 32'h104, 0, 0, 32'h0, 32'h0, 3'b000, 1, 32'h3333_3333);
        checkOutput("sim_c2_read",  m_read,     32'd1);
        checkOutput("sim_c2_ibusy", i_busywait, 32'd0);
        finishCycle();
        idleCycle(0);

        // Alternation under constant contention: D, I, D, I, D, I.
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1, 0, 1, 32'h300, 0, 1, 32'h400, 32'hCAFE_0000 + c, 3'b010, 1, $urandom);
            if (c > 0) checkOutput($sformatf("alt_is_d%0d", c), m_write, (c % 2 == 1) ? 32'd1 : 32'd0);
            finishCycle();
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 3'b000, 1, 32'h0);
            finishCycle();
        end

        // Flush: request drops after one grant cycle, strobe held until the ack.
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1, 0, 0, 32'h0, c < 2, 0, 32'h500, 32'h0, 3'b100, c == 3, 32'h7777_7777);
            if (c == 2 || c == 3) checkOutput("flush_held", m_read, 32'd1);
            if (c == 4)           checkOutput("flush_idle", m_read, 32'd0);
            finishCycle();
        end

        // Watchdog: one good read, then a read memory never acknowledges.
        idleCycle(1);
        for (int c = 0; c < 11; c++) begin
            applyStimulus(1, 0, 0, 32'h0, c <= 6, 0, (c < 2) ? 32'h40 : 32'h44, 32'h0, 3'b010,
                          c == 1, (c == 1) ? 32'h1234_5678 : 32'h9999_9999);
            if (c == 1) checkOutput("wd_good_data", d_readdata, 32'h1234_5678);
            if (c == 6) begin
                checkOutput("wd_dbusy", d_busywait,  32'd0);
                checkOutput("wd_data",  d_readdata,  32'd0);
            end
            if (c >= 7) checkOutput("wd_sticky", timeout_err, 32'd1);
            finishCycle();
        end
        idleCycle(1);
        applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 3'b000, 0, 32'h0);
        checkOutput("wd_cleared", timeout_err, 32'd0);
        finishCycle();

        // Random traffic obeying the hold-until-not-busy request protocol.
        i_pend = 0; d_pend = 0;
        for (int n = 0; n < 1500; n++) begin
            rst_r = ($urandom_range(0, 149) == 0);
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_pend_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_pend_wr = $urandom_range(0, 1) == 1;
                d_pend_addr = $urandom; d_pend_wd = $urandom; d_pend_f3 = 3'($urandom_range(0, 7));
            end
            applyStimulus(1, rst_r, i_pend, i_pend ? i_pend_addr : $urandom,
                          d_pend && !d_pend_wr, d_pend && d_pend_wr,
                          d_pend ? d_pend_addr : $urandom, d_pend ? d_pend_wd : $urandom,
                          d_pend ? d_pend_f3 : 3'($urandom_range(0, 7)),
                          $urandom_range(0, 9) < 4, $urandom);
            if (rst_r) begin
                i_pend = 0; d_pend = 0;
            end else begin
                if (i_pend && !e_ibusy) i_pend = 0;
                if (d_pend && !e_dbusy) d_pend = 0;
            end
            finishCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
